// File: rtl/ram_dp_param.sv
`default_nettype none
// ============================================================================
//  Module      : ram_dp_param
//  Description : Simple dual-port RAM with one write port and one read port,
//                a built-in zero-fill sweep, and selectable read behaviour.
//                - WEN/WADDR/WD : write port, active only while idle
//                - REN/RADDR    : read port, active only while idle
//                - RD/RVALID    : read data (held between reads) and its
//                                 one-cycle valid pulse
//                - CLR          : request a zero-fill of the whole array
//                - BUSY         : high while the zero-fill sweep runs
//                Parameters: DWIDTH (word width), AWIDTH (address width,
//                DEPTH = 2**AWIDTH), RD_MODE (0 = old data on collision,
//                1 = write-through), OUT_REG (0 = 1-cycle, 1 = 2-cycle read
//                latency), CLR_ON_RESET (1 = sweep starts after reset).
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_dp_param #(
    parameter int DWIDTH       = 8,
    parameter int AWIDTH       = 7,
    parameter int RD_MODE      = 0,
    parameter int OUT_REG      = 0,
    parameter int CLR_ON_RESET = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              WEN,
    input  logic [AWIDTH-1:0] WADDR,
    input  logic [DWIDTH-1:0] WD,
    input  logic              REN,
    input  logic [AWIDTH-1:0] RADDR,
    input  logic              CLR,
    output logic [DWIDTH-1:0] RD,
    output logic              RVALID,
    output logic              BUSY
);

    localparam int                c_DEPTH    = 2 ** AWIDTH;
    localparam logic [AWIDTH-1:0] c_CNT_LAST = '1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [AWIDTH-1:0] r_cnt;
    logic [AWIDTH-1:0] w_cnt_nxt;

    logic [DWIDTH-1:0] r_mem [c_DEPTH];

    logic              w_idle;
    logic              w_mem_we;
    logic [AWIDTH-1:0] w_mem_waddr;
    logic [DWIDTH-1:0] w_mem_wdata;
    logic              w_rd_acc;
    logic [DWIDTH-1:0] w_rd_word;

    logic [DWIDTH-1:0] r_rd;
    logic              r_rvalid;

    // ------------------------------------------------------------------
    // Sweep controller
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            // Reset mid-sweep either restarts the sweep from word 0 or
            // abandons it, depending on CLR_ON_RESET.
            if (CLR_ON_RESET != 0) begin
                r_state <= ST_CLEAR;
            end else begin
                r_state <= ST_IDLE;
            end
            r_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (CLR) begin
                    w_state_nxt = ST_CLEAR;
                    w_cnt_nxt   = '0;
                end
            end
            ST_CLEAR: begin
                // CLR is deliberately not looked at here: a request during
                // a sweep neither restarts nor extends it. The counter wraps
                // back to zero on the last word.
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_idle = (r_state == ST_IDLE);
    assign BUSY   = (r_state == ST_CLEAR);

    // ------------------------------------------------------------------
    // Storage array: the sweep owns the write port while clearing.
    // Reset never writes the array.
    // ------------------------------------------------------------------
    assign w_mem_we    = !RESET && (!w_idle || WEN);
    assign w_mem_waddr = w_idle ? WADDR : r_cnt;
    assign w_mem_wdata = w_idle ? WD : '0;

    always_ff @(posedge CLK) begin
        if (w_mem_we) begin
            r_mem[w_mem_waddr] <= w_mem_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Read port
    // ------------------------------------------------------------------
    assign w_rd_acc = !RESET && w_idle && REN;

    // The array read happens before this edge's write lands, so plain
    // r_mem[RADDR] already gives old data on a collision.
    generate
        if (RD_MODE == 1) begin : g_wr_through
            assign w_rd_word = (WEN && (WADDR == RADDR)) ? WD : r_mem[RADDR];
        end else begin : g_rd_old
            assign w_rd_word = r_mem[RADDR];
        end
    endgenerate

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic              r_p1_vld;
            logic [DWIDTH-1:0] r_p1_data;

            // Stage 1 keeps advancing while clearing so reads already in
            // flight still complete.
            always_ff @(posedge CLK) begin
                if (RESET) begin
                    r_p1_vld  <= 1'b0;
                    r_p1_data <= '0;
                    r_rvalid  <= 1'b0;
                    r_rd      <= '0;
                end else begin
                    r_p1_vld <= w_rd_acc;
                    if (w_rd_acc) begin
                        r_p1_data <= w_rd_word;
                    end
                    r_rvalid <= r_p1_vld;
                    if (r_p1_vld) begin
                        r_rd <= r_p1_data;
                    end
                end
            end
        end else begin : g_no_out_reg
            always_ff @(posedge CLK) begin
                if (RESET) begin
                    r_rvalid <= 1'b0;
                    r_rd     <= '0;
                end else begin
                    r_rvalid <= w_rd_acc;
                    if (w_rd_acc) begin
                        r_rd <= w_rd_word;
                    end
                end
            end
        end
    endgenerate

    assign RD     = r_rd;
    assign RVALID = r_rvalid;

endmodule
`default_nettype wire

// File: tb/tb_ram_dp_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_dp_param
//  Description : Self-checking bench for ram_dp_param. Two instances:
//                dut0 uses the defaults (8x128, old-data, 1-cycle, clear on
//                reset); dut1 is 32x16, write-through, output register, no
//                clear on reset. A behavioural model (word array, remaining
//                sweep count, read delay line) predicts every output cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_dp_param;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    // dut0 : defaults
    logic        rst0, wen0, ren0, clr0;
    logic [6:0]  wa0, ra0;
    logic [7:0]  wd0, rd0;
    logic        rv0, busy0;
    // dut1 : DWIDTH=32 AWIDTH=4 RD_MODE=1 OUT_REG=1 CLR_ON_RESET=0
    logic        rst1, wen1, ren1, clr1;
    logic [3:0]  wa1, ra1;
    logic [31:0] wd1, rd1;
    logic        rv1, busy1;

    ram_dp_param dut0 (
        .CLK(CLK), .RESET(rst0), .WEN(wen0), .WADDR(wa0), .WD(wd0),
        .REN(ren0), .RADDR(ra0), .CLR(clr0), .RD(rd0), .RVALID(rv0), .BUSY(busy0)
    );

    ram_dp_param #(
        .DWIDTH(32), .AWIDTH(4), .RD_MODE(1), .OUT_REG(1), .CLR_ON_RESET(0)
    ) dut1 (
        .CLK(CLK), .RESET(rst1), .WEN(wen1), .WADDR(wa1), .WD(wd1),
        .REN(ren1), .RADDR(ra1), .CLR(clr1), .RD(rd1), .RVALID(rv1), .BUSY(busy1)
    );

    int nchk = 0;
    int nerr = 0;
    bit chk_en = 0;

    // ---------------- reference model ----------------
    function automatic int dep(int id);    return (id == 0) ? 128 : 16; endfunction
    function automatic int lat(int id);    return (id == 0) ? 1 : 2;    endfunction
    function automatic bit newd(int id);   return (id == 1);            endfunction
    function automatic bit clrrst(int id); return (id == 0);            endfunction

    logic [31:0] mmem [2][128];
    int          bleft [2];
    int          sptr  [2];
    logic        pv    [2];
    logic [31:0] pd    [2];
    logic        exp_rv   [2];
    logic [31:0] exp_rd   [2];
    logic        exp_busy [2];

    function automatic void model_edge(int id, bit rst, bit wen, int wa, logic [31:0] wd,
                                       bit ren, int ra, bit clr);
        bit          nv;
        logic [31:0] nd;
        if (rst) begin
            bleft[id]  = clrrst(id) ? dep(id) : 0;
            sptr[id]   = 0;
            pv[id]     = 1'b0;
            pd[id]     = '0;
            exp_rv[id] = 1'b0;
            exp_rd[id] = '0;
        end else begin
            nv = 1'b0;
            nd = '0;
            if (bleft[id] > 0) begin
                mmem[id][sptr[id]] = '0;
                sptr[id]++;
                bleft[id]--;
            end else begin
                if (ren) begin
                    nv = 1'b1;
                    nd = (newd(id) && wen && wa == ra) ? wd : mmem[id][ra];
                end
                if (wen) mmem[id][wa] = wd;
                if (clr) begin
                    bleft[id] = dep(id);
                    sptr[id]  = 0;
                end
            end
            if (lat(id) == 1) begin
                exp_rv[id] = nv;
                if (nv) exp_rd[id] = nd;
            end else begin
                exp_rv[id] = pv[id];
                if (pv[id]) exp_rd[id] = pd[id];
                pv[id] = nv;
                pd[id] = nd;
            end
        end
        exp_busy[id] = (bleft[id] > 0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nchk++;
        assert (obs === expv)
        else begin
            nerr++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        model_edge(0, rst0, wen0, int'(wa0), {24'b0, wd0}, ren0, int'(ra0), clr0);
        model_edge(1, rst1, wen1, int'(wa1), wd1, ren1, int'(ra1), clr1);
        #1;
        if (chk_en) begin
            chk("rd0",   {24'b0, rd0}, exp_rd[0]);
            chk("rv0",   {31'b0, rv0}, {31'b0, exp_rv[0]});
            chk("busy0", {31'b0, busy0}, {31'b0, exp_busy[0]});
            chk("rd1",   rd1, exp_rd[1]);
            chk("rv1",   {31'b0, rv1}, {31'b0, exp_rv[1]});
            chk("busy1", {31'b0, busy1}, {31'b0, exp_busy[1]});
        end
    endtask

    task automatic idle_inputs();
        wen0 = 0; ren0 = 0; clr0 = 0; wa0 = '0; ra0 = '0; wd0 = '0;
        wen1 = 0; ren1 = 0; clr1 = 0; wa1 = '0; ra1 = '0; wd1 = '0;
    endtask

    int busy_cnt;

    initial begin
        idle_inputs();
        rst0 = 1; rst1 = 1;
        tick();
        chk_en = 1;
        tick();
        // Reset state: RD=0, RVALID=0, BUSY only for the clear-on-reset instance
        chk("rst_rd0", {24'b0, rd0}, 32'h0);
        chk("rst_busy0", {31'b0, busy0}, 32'h1);
        chk("rst_busy1", {31'b0, busy1}, 32'h0);

        // Release reset; dut0 sweeps 128 cycles while being hammered with
        // ignored writes/reads/clears. dut1 gets an explicit clear.
        rst0 = 0; rst1 = 0;
        clr1 = 1;
        busy_cnt = 0;
        for (int i = 0; i < 128; i++) begin
            wen0 = 1'($urandom); ren0 = 1'($urandom); clr0 = 1'($urandom);
            wa0 = 7'($urandom); ra0 = 7'($urandom); wd0 = 8'($urandom);
            tick();
            clr1 = 0;
            if (busy0) busy_cnt++;
        end
        idle_inputs();
        chk("sweep_len0", busy_cnt, 32'd127);
        chk("sweep_done0", {31'b0, busy0}, 32'h0);

        // Read every word back-to-back: all zero, RVALID continuous
        for (int a = 0; a < 128; a++) begin
            ren0 = 1; ra0 = 7'(a);
            tick();
            chk("zero_rv0", {31'b0, rv0}, 32'h1);
        end
        ren0 = 0;
        tick();
        chk("hold_rv0", {31'b0, rv0}, 32'h0);

        // Write 0xA5 @0x10, read it next cycle
        wen0 = 1; wa0 = 7'h10; wd0 = 8'hA5;
        tick();
        wen0 = 0; ren0 = 1; ra0 = 7'h10;
        tick();
        ren0 = 0;
        chk("a5_rd0", {24'b0, rd0}, 32'hA5);

        // Collision, old-data mode
        wen0 = 1; wa0 = 7'h05; wd0 = 8'h3C;
        tick();
        wd0 = 8'hC3; ren0 = 1; ra0 = 7'h05;
        tick();
        chk("coll_old0", {24'b0, rd0}, 32'h3C);
        wen0 = 0;
        tick();
        ren0 = 0;
        chk("coll_next0", {24'b0, rd0}, 32'hC3);

        // CLR + WEN + REN together: write lands, read returns pre-clear data
        clr0 = 1; wen0 = 1; wa0 = 7'h05; wd0 = 8'h11; ren0 = 1; ra0 = 7'h05;
        tick();
        idle_inputs();
        chk("triple_rd0", {24'b0, rd0}, 32'hC3);
        chk("triple_busy0", {31'b0, busy0}, 32'h1);
        for (int i = 0; i < 130; i++) tick();

        // Reset at sweep count 60 restarts the sweep
        clr0 = 1;
        tick();
        clr0 = 0;
        for (int i = 0; i < 60; i++) tick();
        rst0 = 1;
        tick();
        rst0 = 0;
        busy_cnt = 0;
        for (int i = 0; i < 130; i++) begin
            tick();
            if (busy0) busy_cnt++;
        end
        chk("rst_restart0", busy_cnt, 32'd127);

        // dut1: 32-bit word at the top address, two-cycle latency
        wen1 = 1; wa1 = 4'hF; wd1 = 32'hDEADBEEF;
        tick();
        wen1 = 0; ren1 = 1; ra1 = 4'hF;
        tick();
        ren1 = 0;
        chk("beef_early_rv1", {31'b0, rv1}, 32'h0);
        tick();
        chk("beef_rd1", rd1, 32'hDEADBEEF);
        chk("beef_rv1", {31'b0, rv1}, 32'h1);

        // dut1 collision, write-through mode
        wen1 = 1; wa1 = 4'h5; wd1 = 32'h0000003C;
        tick();
        wd1 = 32'h000000C3; ren1 = 1; ra1 = 4'h5;
        tick();
        wen1 = 0; ren1 = 0;
        tick();
        chk("coll_new1", rd1, 32'hC3);

        // dut1 reset mid-sweep aborts the sweep
        clr1 = 1;
        tick();
        clr1 = 0;
        for (int i = 0; i < 5; i++) tick();
        rst1 = 1;
        tick();
        rst1 = 0;
        tick();
        chk("abort_busy1", {31'b0, busy1}, 32'h0);
        clr1 = 1;
        tick();
        clr1 = 0;
        for (int i = 0; i < 20; i++) tick();

        // Random traffic on both instances
        for (int i = 0; i < 1500; i++) begin
            wen0 = 1'($urandom); ren0 = 1'($urandom);
            wa0 = 7'($urandom); ra0 = 7'($urandom); wd0 = 8'($urandom);
            clr0 = ($urandom_range(0, 99) == 0);
            rst0 = ($urandom_range(0, 299) == 0);
            wen1 = 1'($urandom); ren1 = 1'($urandom);
            wa1 = 4'($urandom); ra1 = 4'($urandom); wd1 = $urandom;
            clr1 = ($urandom_range(0, 49) == 0);
            rst1 = ($urandom_range(0, 299) == 0);
            tick();
        end
        idle_inputs();
        rst0 = 0; rst1 = 0;
        tick();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
`default_nettype wire
